// File: rtl/calc_btn_cond_pkg.sv
// Shared constants for the calculator button conditioner: debounce defaults
// and the chord bit order that the encoder and ALU control also rely on.
package calc_btn_cond_pkg;

  localparam int DEB_CYCLES_DEF  = 500000;
  localparam int DEB_CYCLES_SIM  = 4;
  localparam int SYNC_STAGES_DEF = 2;

  // Chord bit positions, also used as debouncer slot indices.
  localparam int CHORD_R = 0;
  localparam int CHORD_C = 1;
  localparam int CHORD_L = 2;
  localparam int BTN_D   = 3;
  localparam int NUM_BTN = 4;

  // Field order mirrors CHORD_L/C/R so the packed value is {l,c,r}.
  typedef struct packed {
    logic l;
    logic c;
    logic r;
  } chord_t;

  function automatic chord_t make_chord(input logic l, input logic c, input logic r);
    chord_t ch;
    ch.l = l;
    ch.c = c;
    ch.r = r;
    return ch;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button input: multi-flop synchroniser followed by a hold-time
// debouncer that only accepts a level held for DEB_CYCLES consecutive cycles.
module btn_debounce
  import calc_btn_cond_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // The counter only runs while s disagrees with level and is cleared on
  // acceptance, so it tops out at DEB_CYCLES-1 and cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/calc_btn_cond.sv
// Button conditioner for the calculator: debounced l/c/r levels plus a
// one-cycle execute pulse and the chord captured on each accepted btnd press.
module calc_btn_cond
  import calc_btn_cond_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnl_raw,
  input  logic       btnc_raw,
  input  logic       btnr_raw,
  input  logic       btnd_raw,
  output logic       btnl,
  output logic       btnc,
  output logic       btnr,
  output logic       exec_pulse,
  output logic [2:0] chord
);

  logic [NUM_BTN-1:0] raw_bus;
  logic [NUM_BTN-1:0] lvl_bus;
  logic               btnd_db;
  logic               btnd_q;
  logic               btnd_rise;
  chord_t             lvl_q;

  always_comb begin
    raw_bus          = '0;
    raw_bus[CHORD_L] = btnl_raw;
    raw_bus[CHORD_C] = btnc_raw;
    raw_bus[CHORD_R] = btnr_raw;
    raw_bus[BTN_D]   = btnd_raw;
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_bus[i]),
      .level(lvl_bus[i])
    );
  end

  assign btnl      = lvl_bus[CHORD_L];
  assign btnc      = lvl_bus[CHORD_C];
  assign btnr      = lvl_bus[CHORD_R];
  assign btnd_db   = lvl_bus[BTN_D];
  assign btnd_rise = btnd_db & ~btnd_q;

  // lvl_q lags the levels by one cycle, so on the rise of btnd_db it still
  // holds the chord from before that edge: a chord button settling in the
  // same cycle as btnd is not included in the capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btnd_q     <= 1'b0;
      lvl_q      <= '0;
      exec_pulse <= 1'b0;
      chord      <= 3'b000;
    end else begin
      btnd_q     <= btnd_db;
      lvl_q      <= make_chord(btnl, btnc, btnr);
      exec_pulse <= btnd_rise;
      if (btnd_rise) begin
        chord <= lvl_q;
      end
    end
  end

endmodule

// File: tb/tb_calc_btn_cond.sv
// Randomised and directed bench for calc_btn_cond with a run-length reference
// model of debounce and press detection, checked every cycle on the falling edge.
module tb_calc_btn_cond;

  localparam int DEB  = 4;
  localparam int SYNC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btnl_raw = 1'b0, btnc_raw = 1'b0, btnr_raw = 1'b0, btnd_raw = 1'b0;
  logic btnl, btnc, btnr, exec_pulse;
  logic [2:0] chord;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  calc_btn_cond #(.DEB_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n),
    .btnl_raw(btnl_raw), .btnc_raw(btnc_raw), .btnr_raw(btnr_raw), .btnd_raw(btnd_raw),
    .btnl(btnl), .btnc(btnc), .btnr(btnr), .exec_pulse(exec_pulse), .chord(chord)
  );

  // Reference model. Slot order: 3=d, 2=l, 1=c, 0=r.
  // A level is accepted once the pin value seen SYNC samples late has
  // disagreed with the current level for DEB consecutive samples.
  logic [3:0] m_lvl = '0;
  int         m_run [4];
  logic       m_delay [4][$];
  logic       m_rose = 1'b0;
  logic [2:0] m_rise_chord = '0;
  logic       m_exec = 1'b0;
  logic [2:0] m_chord = '0;

  always @(posedge clk) begin
    logic [3:0] pins;
    logic       old_d;
    logic       s;
    pins = {btnd_raw, btnl_raw, btnc_raw, btnr_raw};
    if (!rst_n) begin
      m_lvl = '0; m_rose = 1'b0; m_exec = 1'b0; m_chord = '0; m_rise_chord = '0;
      for (int b = 0; b < 4; b++) begin
        m_run[b] = 0;
        m_delay[b].delete();
        for (int k = 0; k < SYNC; k++) m_delay[b].push_back(1'b0);
      end
    end else begin
      m_exec = m_rose;
      if (m_rose) begin
        m_chord = m_rise_chord;
        exp_q.push_back(m_rise_chord);
      end
      m_rise_chord = m_lvl[2:0];
      old_d = m_lvl[3];
      for (int b = 0; b < 4; b++) begin
        s = m_delay[b].pop_front();
        m_delay[b].push_back(pins[b]);
        if (s != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_lvl[b] = s;
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_rose = m_lvl[3] & ~old_d;
    end
  end

  function automatic logic [6:0] dut_vec();
    return {btnl, btnc, btnr, exec_pulse, chord};
  endfunction

  function automatic logic [6:0] model_vec();
    return {m_lvl[2:0], m_exec, m_chord};
  endfunction

  // driver tasks / scenarios
  task automatic test_reset();
    int pulses = 0;
    int rise_at = -1;
    btnl_raw = 1; btnc_raw = 1; btnr_raw = 1; btnd_raw = 1; rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== 7'd0) begin
        miscompares++;
        $display("FAIL reset_hold got=%b exp=%b", dut_vec(), 7'd0);
      end
    end
    rst_n = 1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
      if (exec_pulse === 1'b1) pulses++;
      if (btnl === 1'b1 && rise_at < 0) rise_at = i;
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL reset_pulse_count got=%0d exp=1", pulses);
    end
    vectors++;
    if (rise_at !== SYNC + DEB) begin
      miscompares++;
      $display("FAIL reset_redebounce got=%0d exp=%0d", rise_at, SYNC + DEB);
    end
    btnl_raw = 0; btnc_raw = 0; btnr_raw = 0; btnd_raw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL reset_clear got=%b exp=%b", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    int rise_at = -1;
    int fall_at = -1;
    btnl_raw = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL press_model cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
      if (btnl === 1'b1 && rise_at < 0) rise_at = i;
    end
    vectors++;
    if (rise_at !== SYNC + DEB) begin
      miscompares++;
      $display("FAIL press_rise_latency got=%0d exp=%0d", rise_at, SYNC + DEB);
    end
    btnl_raw = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL release_model cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
      if (btnl === 1'b0 && fall_at < 0) fall_at = i;
    end
    vectors++;
    if (fall_at !== SYNC + DEB) begin
      miscompares++;
      $display("FAIL release_fall_latency got=%0d exp=%0d", fall_at, SYNC + DEB);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] seq = 4'b1010;
    int rise_at = -1;
    for (int i = 3; i >= 0; i--) begin
      btnc_raw = seq[i];
      @(negedge clk);
      vectors++;
      if (btnc !== 1'b0 || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL bounce_hold btnc=%b vec=%b exp=%b", btnc, dut_vec(), model_vec());
      end
    end
    btnc_raw = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL bounce_model cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
      if (btnc === 1'b1 && rise_at < 0) rise_at = i;
    end
    vectors++;
    if (rise_at !== SYNC + DEB) begin
      miscompares++;
      $display("FAIL bounce_settle got=%0d exp=%0d", rise_at, SYNC + DEB);
    end
    btnc_raw = 0;
    for (int i = 0; i < 10; i++) @(negedge clk);
  endtask

  task automatic test_execute();
    int pulses = 0;
    logic [2:0] e;
    btnl_raw = 1; btnr_raw = 1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      btnd_raw = (i < 20);
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL exec_model cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
      if (exec_pulse === 1'b1) begin
        pulses++;
        vectors++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
        if (chord !== e || chord !== 3'b101) begin
          miscompares++;
          $display("FAIL exec_chord got=%b exp=%b", chord, 3'b101);
        end
      end
    end
    vectors++;
    if (pulses !== 1 || chord !== 3'b101) begin
      miscompares++;
      $display("FAIL exec_single pulses=%0d chord=%b exp pulses=1 chord=101", pulses, chord);
    end
  endtask

  task automatic test_double_press();
    int pulses = 0;
    logic [2:0] e;
    exp_q.delete();
    for (int p = 0; p < 3; p++) begin
      btnd_raw = (p != 1);
      if (p == 1) begin
        btnl_raw = 0; btnr_raw = 0; btnc_raw = 1;
      end
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        vectors++;
        if (dut_vec() !== model_vec()) begin
          miscompares++;
          $display("FAIL double_model ph=%0d got=%b exp=%b", p, dut_vec(), model_vec());
        end
        if (exec_pulse === 1'b1) begin
          pulses++;
          vectors++;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
          if (chord !== e) begin
            miscompares++;
            $display("FAIL double_chord got=%b exp=%b", chord, e);
          end
        end
      end
    end
    vectors++;
    if (pulses !== 2 || chord !== 3'b010) begin
      miscompares++;
      $display("FAIL double_press pulses=%0d chord=%b exp pulses=2 chord=010", pulses, chord);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    btnd_raw = 0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 15; i++) begin
      btnd_raw = (i < 3);
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL glitch_model cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
      if (exec_pulse === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0 || chord !== 3'b010) begin
      miscompares++;
      $display("FAIL glitch_reject pulses=%0d chord=%b exp pulses=0 chord=010", pulses, chord);
    end
  endtask

  task automatic test_random();
    logic [3:0] pins;
    logic [2:0] e;
    int hold = 0;
    exp_q.delete();
    for (int i = 0; i < 500; i++) begin
      if (hold == 0) begin
        pins = 4'($urandom_range(0, 15));
        {btnd_raw, btnl_raw, btnc_raw, btnr_raw} = pins;
        hold = $urandom_range(1, 12);
      end
      hold--;
      rst_n = !(i >= 250 && i < 252);
      @(negedge clk);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
      if (exec_pulse === 1'b1) begin
        vectors++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
        if (chord !== e) begin
          miscompares++;
          $display("FAIL random_chord cyc=%0d got=%b exp=%b", i, chord, e);
        end
      end
    end
    rst_n = 1;
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL random_missed_pulses got=%0d pending exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_execute();
    test_double_press();
    test_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
